// File: rtl/laser500_pkg.sv
// Shared types and default constants for the Laser 500 SDRAM port arbiter.
package laser500_pkg;

  // Which requester currently owns the SDRAM port.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DIO  = 2'd1,
    OWN_VID  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

  // Arbiter FSM: IDLE picks a winner, BUSY waits for mem_ack or the timeout.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Consecutive video grants allowed while the CPU is waiting.
  localparam int VID_MAX_RUN = 4;
  // Cycles spent in BUSY without mem_ack before the access is abandoned.
  localparam int TIMEOUT     = 15;

endpackage

// File: rtl/sdram_arbiter_req_latch.sv
// Single-entry pending slot for a pulsed write requester. A write strobe
// captures address/data and raises pend_o until the slot is granted. A strobe
// landing on an already-pending slot overwrites it and flags a sticky overrun;
// a strobe landing in the grant cycle simply refills the slot.
module arb_req_latch #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              grant_i,
  output logic              pend_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              overrun_o
);

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              overrun_q, overrun_d;

  // Slot next-state: grant empties the slot, a new strobe refills it.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pend_d    = pend_q;
    addr_d    = addr_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (grant_i) pend_d = 1'b0;
    if (wr_i) begin
      pend_d = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
      if (pend_q && !grant_i) overrun_d = 1'b1;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      pend_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign pend_o    = pend_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between ROM download, video fetch and the
// Z80 CPU. Download beats video beats CPU, except that the CPU is let in after
// VID_MAX_RUN video grants so it cannot starve. The CPU is held with WAIT_n.
module sdram_arbiter
  import laser500_pkg::*;
#(
  parameter int ADDR_W      = 25,
  parameter int VID_MAX_RUN = laser500_pkg::VID_MAX_RUN,
  parameter int TIMEOUT     = laser500_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dio_wr,
  input  logic [ADDR_W-1:0] dio_addr,
  input  logic [7:0]        dio_data,
  output logic              dio_overrun,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_wait_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              arb_error
);

  localparam int RUN_W = $clog2(VID_MAX_RUN + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(VID_MAX_RUN);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            winner;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              arb_error_q, arb_error_d;
  logic              cpu_req_q, cpu_pend_q, cpu_pend_d;
  logic              cpu_wait_n_q, cpu_wait_n_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              dio_pend, dio_grant;
  logic [ADDR_W-1:0] dio_slot_addr;
  logic [7:0]        dio_slot_data;
  logic              timed_out, xfer_done, cpu_done, cpu_rise;

  arb_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_dio_latch (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_i      (dio_wr),
    .addr_i    (dio_addr),
    .data_i    (dio_data),
    .grant_i   (dio_grant),
    .pend_o    (dio_pend),
    .addr_o    (dio_slot_addr),
    .data_o    (dio_slot_data),
    .overrun_o (dio_overrun)
  );

  // A new CPU access only starts on a rising request, never on a held level.
  assign cpu_rise  = cpu_req && !cpu_req_q;
  assign timed_out = (state_q == ST_BUSY) && !mem_ack && (tmo_q == TMO_LAST);
  assign xfer_done = (state_q == ST_BUSY) && (mem_ack || timed_out);
  assign cpu_done  = xfer_done && (owner_q == OWN_CPU);
  assign dio_grant = (state_q == ST_IDLE) && (winner == OWN_DIO);

  // Priority pick; the CPU jumps the video queue once the run limit is hit.
  always_comb begin
    winner = OWN_NONE;
    if (dio_pend)                              winner = OWN_DIO;
    else if (cpu_pend_q && run_q == RUN_LIMIT) winner = OWN_CPU;
    else if (vid_req)                          winner = OWN_VID;
    else if (cpu_pend_q)                       winner = OWN_CPU;
  end

  // Port FSM: launch the winner from IDLE, hold mem_* stable through BUSY.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    run_d       = run_q;
    tmo_d       = tmo_q;
    arb_error_d = arb_error_q;
    case (state_q)
      ST_IDLE: begin
        if (winner != OWN_NONE) begin
          state_d   = ST_BUSY;
          owner_d   = winner;
          mem_req_d = 1'b1;
          tmo_d     = '0;
          case (winner)
            OWN_DIO: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = dio_slot_addr;
              mem_wdata_d = dio_slot_data;
            end
            OWN_VID: begin
              mem_we_d    = 1'b0;
              mem_addr_d  = vid_addr;
              mem_wdata_d = '0;
              if (cpu_pend_q) run_d = run_q + RUN_W'(1);
            end
            OWN_CPU: begin
              mem_we_d    = cpu_we;
              mem_addr_d  = ADDR_W'(cpu_addr);
              mem_wdata_d = cpu_wdata;
              run_d       = '0;
            end
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (xfer_done) begin
          state_d   = ST_IDLE;
          owner_d   = OWN_NONE;
          mem_req_d = 1'b0;
          if (timed_out) arb_error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CPU handshake: stall on a new request, release and return data on completion.
  always_comb begin
    cpu_pend_d   = cpu_pend_q;
    cpu_wait_n_d = cpu_wait_n_q;
    cpu_rdata_d  = cpu_rdata_q;
    if (cpu_done) begin
      cpu_pend_d   = 1'b0;
      cpu_wait_n_d = 1'b1;
      if (!mem_we_q) cpu_rdata_d = mem_ack ? mem_rdata : 8'hFF;
    end
    if (cpu_rise) begin
      cpu_pend_d   = 1'b1;
      cpu_wait_n_d = 1'b0;
    end
  end

  // State registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      run_q        <= '0;
      tmo_q        <= '0;
      arb_error_q  <= 1'b0;
      cpu_req_q    <= 1'b0;
      cpu_pend_q   <= 1'b0;
      cpu_wait_n_q <= 1'b1;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      run_q        <= run_d;
      tmo_q        <= tmo_d;
      arb_error_q  <= arb_error_d;
      cpu_req_q    <= cpu_req;
      cpu_pend_q   <= cpu_pend_d;
      cpu_wait_n_q <= cpu_wait_n_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  // Video data is taken straight from mem_rdata, so its ack rides with mem_ack.
  assign vid_ack    = xfer_done && (owner_q == OWN_VID);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_wait_n = cpu_wait_n_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign arb_error  = arb_error_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a latency-configurable SDRAM model, a video
// requester that drops vid_req on vid_ack, and a grant scoreboard that checks
// every mem_req launch against the expected owner/address/data sequence.
module tb_sdram_arbiter;

  localparam int AW = 25;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
  } grant_t;

  logic          clk, reset_n;
  logic          dio_wr, dio_overrun;
  logic [AW-1:0] dio_addr, vid_addr, mem_addr;
  logic [7:0]    dio_data, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic          vid_req, vid_ack;
  logic          cpu_req, cpu_we, cpu_wait_n;
  logic [15:0]   cpu_addr;
  logic          mem_req, mem_we, mem_ack, arb_error;

  int     n_run, n_fail, grant_cnt, vid_ack_cnt;
  int     ack_lat;
  logic   ack_en, vid_keep;
  grant_t exp_q[$];

  sdram_arbiter u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dio_wr      (dio_wr),
    .dio_addr    (dio_addr),
    .dio_data    (dio_data),
    .dio_overrun (dio_overrun),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_ack     (vid_ack),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_wait_n  (cpu_wait_n),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .arb_error   (arb_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic grant_t mk(input logic we, input logic [AW-1:0] addr, input logic [7:0] wdata);
    grant_t g;
    g.we = we; g.addr = addr; g.wdata = wdata;
    return g;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // SDRAM model: acks ack_lat cycles after mem_req rises; read data = addr[7:0] ^ 0x5A.
  initial begin
    int lat_cnt;
    lat_cnt = 0; mem_ack = 1'b0; mem_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0; lat_cnt = 0;
      end else if (mem_req === 1'b1) begin
        lat_cnt++;
        if (ack_en && lat_cnt >= ack_lat) begin
          mem_ack = 1'b1;
          mem_rdata = mem_addr[7:0] ^ 8'h5A;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Grant scoreboard plus video requester that releases vid_req on its ack.
  initial begin
    grant_t e;
    logic   req_prev;
    int     low_cnt;
    req_prev = 1'b0; low_cnt = 1;
    forever begin
      @(negedge clk);
      if (vid_ack === 1'b1) begin
        vid_ack_cnt++;
        if (!vid_keep) vid_req = 1'b0;
      end
      if (mem_req === 1'b1 && !req_prev) begin
        grant_cnt++;
        n_run++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL grant_unexpected: got we=%0b addr=%h, required no grant", mem_we, mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
            n_fail++;
            $display("FAIL grant_order: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                     mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
          end
        end
        n_run++;
        if (low_cnt < 1) begin
          n_fail++;
          $display("FAIL grant_gap: got %0d idle cycles, required at least 1", low_cnt);
        end
      end
      if (mem_req === 1'b1) low_cnt = 0; else low_cnt++;
      req_prev = (mem_req === 1'b1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_run++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got req=%b we=%b, required 0 0", mem_req, mem_we); end
    n_run++; if (mem_addr !== '0 || mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_bus: got addr=%h data=%h, required 0", mem_addr, mem_wdata); end
    n_run++; if (cpu_wait_n !== 1'b1 || cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_cpu: got wait_n=%b rdata=%h, required 1 00", cpu_wait_n, cpu_rdata); end
    n_run++; if (vid_ack !== 1'b0 || dio_overrun !== 1'b0 || arb_error !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ack=%b ovr=%b err=%b, required 0", vid_ack, dio_overrun, arb_error); end
    step(1);
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic test_cpu_read();
    int g0, i;
    ack_lat = 3; ack_en = 1'b1; g0 = grant_cnt;
    exp_q.push_back(mk(1'b0, 25'h0008000, 8'h00));
    cpu_we = 1'b0; cpu_addr = 16'h8000; cpu_req = 1'b1;
    @(negedge clk);
    n_run++; if (cpu_wait_n !== 1'b1) begin n_fail++; $display("FAIL cpu_wait_early: got %b, required 1", cpu_wait_n); end
    @(negedge clk);
    n_run++; if (cpu_wait_n !== 1'b0) begin n_fail++; $display("FAIL cpu_wait_stall: got %b, required 0", cpu_wait_n); end
    i = 0;
    while (mem_ack !== 1'b1 && i < 30) begin @(negedge clk); i++; end
    n_run++; if (mem_ack !== 1'b1) begin n_fail++; $display("FAIL cpu_ack_wait: got no mem_ack, required one within 30 cycles"); end
    n_run++; if (cpu_wait_n !== 1'b0) begin n_fail++; $display("FAIL cpu_wait_at_ack: got %b, required 0", cpu_wait_n); end
    @(negedge clk);
    n_run++; if (cpu_wait_n !== 1'b1) begin n_fail++; $display("FAIL cpu_wait_release: got %b, required 1", cpu_wait_n); end
    n_run++; if (cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL cpu_rdata: got %h, required 5a", cpu_rdata); end
    repeat (10) @(negedge clk);
    n_run++; if (grant_cnt - g0 != 1) begin n_fail++; $display("FAIL cpu_single_access: got %0d grants, required 1", grant_cnt - g0); end
    n_run++; if (cpu_wait_n !== 1'b1) begin n_fail++; $display("FAIL cpu_held_req: got wait_n=%b, required 1", cpu_wait_n); end
    cpu_req = 1'b0;
    step(2);
    n_run++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL cpu_read_left: got %0d pending grants, required 0", exp_q.size()); end
  endtask

  // All three requests land together while a preceding download is in flight,
  // so all of them are waiting at the same IDLE decision.
  task automatic test_simultaneous();
    int i;
    ack_lat = 2; vid_keep = 1'b0;
    exp_q.push_back(mk(1'b1, 25'h0000001, 8'h11));
    exp_q.push_back(mk(1'b1, 25'h0000123, 8'hAA));
    exp_q.push_back(mk(1'b0, 25'h0001000, 8'h00));
    exp_q.push_back(mk(1'b1, 25'h0004000, 8'h77));
    dio_wr = 1'b1; dio_addr = 25'h0000001; dio_data = 8'h11;
    step(1);
    dio_wr = 1'b0;
    i = 0;
    while (mem_req !== 1'b1 && i < 10) begin @(negedge clk); i++; end
    step(1);
    dio_wr = 1'b1; dio_addr = 25'h0000123; dio_data = 8'hAA;
    vid_req = 1'b1; vid_addr = 25'h0001000;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_wdata = 8'h77;
    step(1);
    dio_wr = 1'b0;
    i = 0;
    while ((exp_q.size() != 0 || cpu_wait_n !== 1'b1) && i < 60) begin @(negedge clk); i++; end
    n_run++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL simul_grants: got %0d missing grants, required 0", exp_q.size()); end
    n_run++; if (cpu_wait_n !== 1'b1) begin n_fail++; $display("FAIL simul_cpu_done: got wait_n=%b, required 1", cpu_wait_n); end
    n_run++; if (vid_req !== 1'b0) begin n_fail++; $display("FAIL simul_vid_ack: got vid_req=%b, required 0", vid_req); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    step(3);
  endtask

  // Second strobe lands exactly in the grant cycle of the first: no overrun.
  task automatic test_dio_back_to_back();
    int i;
    ack_lat = 2;
    exp_q.push_back(mk(1'b1, 25'h0000300, 8'h33));
    exp_q.push_back(mk(1'b1, 25'h0000301, 8'h44));
    dio_wr = 1'b1; dio_addr = 25'h0000300; dio_data = 8'h33;
    step(1);
    dio_addr = 25'h0000301; dio_data = 8'h44;
    step(1);
    dio_wr = 1'b0;
    i = 0;
    while ((exp_q.size() != 0 || mem_req !== 1'b0) && i < 30) begin @(negedge clk); i++; end
    n_run++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL dio_b2b_grants: got %0d missing grants, required 0", exp_q.size()); end
    n_run++; if (dio_overrun !== 1'b0) begin n_fail++; $display("FAIL dio_b2b_overrun: got %b, required 0", dio_overrun); end
    step(2);
  endtask

  task automatic test_vid_run();
    int g0, g, i;
    logic raised1, dropped, raised2;
    ack_lat = 1; vid_keep = 1'b1; g0 = grant_cnt;
    raised1 = 1'b0; dropped = 1'b0; raised2 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) exp_q.push_back(mk(1'b0, 25'h0002000, 8'h00));
      exp_q.push_back(mk(1'b0, 25'h0000100, 8'h00));
    end
    exp_q.push_back(mk(1'b0, 25'h0002000, 8'h00));
    cpu_we = 1'b0; cpu_addr = 16'h0100;
    vid_req = 1'b1; vid_addr = 25'h0002000;
    i = 0;
    while (i < 300) begin
      @(negedge clk); #1;
      g = grant_cnt - g0;
      if (g == 1 && !raised1) begin cpu_req = 1'b1; raised1 = 1'b1; end
      if (g == 6 && !dropped) begin cpu_req = 1'b0; dropped = 1'b1; end
      if (g == 7 && !raised2) begin cpu_req = 1'b1; raised2 = 1'b1; end
      if (g == 12) vid_keep = 1'b0;
      if (g >= 13 && vid_req === 1'b0) break;
      i++;
    end
    n_run++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL vid_run_grants: got %0d missing grants, required 0", exp_q.size()); end
    step(4);
    n_run++; if (grant_cnt - g0 != 13) begin n_fail++; $display("FAIL vid_run_total: got %0d grants, required 13", grant_cnt - g0); end
    n_run++; if (cpu_wait_n !== 1'b1 || cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL vid_run_cpu: got wait_n=%b rdata=%h, required 1 5a", cpu_wait_n, cpu_rdata); end
    cpu_req = 1'b0;
    step(2);
  endtask

  task automatic test_dio_overrun();
    int i;
    ack_lat = 8; vid_keep = 1'b0;
    exp_q.push_back(mk(1'b0, 25'h0003000, 8'h00));
    exp_q.push_back(mk(1'b1, 25'h0000204, 8'h22));
    vid_req = 1'b1; vid_addr = 25'h0003000;
    i = 0;
    while (mem_req !== 1'b1 && i < 10) begin @(negedge clk); i++; end
    step(1);
    dio_wr = 1'b1; dio_addr = 25'h0000200; dio_data = 8'h11;
    step(1);
    dio_wr = 1'b0;
    step(1);
    n_run++; if (dio_overrun !== 1'b0) begin n_fail++; $display("FAIL dio_first_write: got overrun=%b, required 0", dio_overrun); end
    dio_wr = 1'b1; dio_addr = 25'h0000204; dio_data = 8'h22;
    step(1);
    dio_wr = 1'b0;
    n_run++; if (dio_overrun !== 1'b1) begin n_fail++; $display("FAIL dio_overrun: got %b, required 1", dio_overrun); end
    i = 0;
    while ((exp_q.size() != 0 || mem_req !== 1'b0) && i < 40) begin @(negedge clk); i++; end
    n_run++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL dio_overrun_grants: got %0d missing grants, required 0", exp_q.size()); end
    step(2);
  endtask

  task automatic test_timeout();
    int i, hi;
    ack_en = 1'b0;
    exp_q.push_back(mk(1'b0, 25'h0000055, 8'h00));
    cpu_we = 1'b0; cpu_addr = 16'h0055; cpu_req = 1'b1;
    i = 0;
    while (mem_req !== 1'b1 && i < 10) begin @(negedge clk); i++; end
    hi = 0;
    while (mem_req === 1'b1 && hi < 40) begin @(negedge clk); hi++; end
    n_run++; if (hi != 15) begin n_fail++; $display("FAIL timeout_len: got %0d busy cycles, required 15", hi); end
    n_run++; if (arb_error !== 1'b1) begin n_fail++; $display("FAIL timeout_error: got %b, required 1", arb_error); end
    n_run++; if (cpu_wait_n !== 1'b1) begin n_fail++; $display("FAIL timeout_wait: got %b, required 1", cpu_wait_n); end
    n_run++; if (cpu_rdata !== 8'hFF) begin n_fail++; $display("FAIL timeout_rdata: got %h, required ff", cpu_rdata); end
    cpu_req = 1'b0; ack_en = 1'b1;
    step(2);
  endtask

  task automatic test_reset_busy();
    int i, acks0;
    ack_en = 1'b0;
    exp_q.push_back(mk(1'b0, 25'h0000077, 8'h00));
    cpu_we = 1'b0; cpu_addr = 16'h0077; cpu_req = 1'b1;
    i = 0;
    while (mem_req !== 1'b1 && i < 10) begin @(negedge clk); i++; end
    repeat (3) @(negedge clk);
    n_run++; if (mem_req !== 1'b1 || cpu_wait_n !== 1'b0) begin n_fail++; $display("FAIL rst_busy_pre: got req=%b wait_n=%b, required 1 0", mem_req, cpu_wait_n); end
    acks0 = vid_ack_cnt;
    #2 reset_n = 1'b0;
    #1;
    n_run++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_busy_req: got %b, required 0", mem_req); end
    n_run++; if (cpu_wait_n !== 1'b1 || arb_error !== 1'b0) begin n_fail++; $display("FAIL rst_busy_cpu: got wait_n=%b err=%b, required 1 0", cpu_wait_n, arb_error); end
    cpu_req = 1'b0; ack_en = 1'b1;
    step(2);
    reset_n = 1'b1;
    step(2);
    n_run++; if (vid_ack_cnt != acks0 || cpu_wait_n !== 1'b1) begin n_fail++; $display("FAIL rst_busy_quiet: got acks=%0d wait_n=%b, required 0 1", vid_ack_cnt - acks0, cpu_wait_n); end
    ack_lat = 2; vid_keep = 1'b0;
    exp_q.push_back(mk(1'b0, 25'h0000444, 8'h00));
    vid_req = 1'b1; vid_addr = 25'h0000444;
    i = 0;
    while (vid_req !== 1'b0 && i < 20) begin @(negedge clk); i++; end
    n_run++; if (vid_ack_cnt - acks0 != 1) begin n_fail++; $display("FAIL rst_resume: got %0d video acks, required 1", vid_ack_cnt - acks0); end
    step(3);
    n_run++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_resume_grants: got %0d missing grants, required 0", exp_q.size()); end
  endtask

  initial begin
    n_run = 0; n_fail = 0; grant_cnt = 0; vid_ack_cnt = 0;
    ack_lat = 3; ack_en = 1'b1; vid_keep = 1'b0;
    reset_n = 1'b0;
    dio_wr = 1'b0; dio_addr = '0; dio_data = 8'h00;
    vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    test_reset();
    test_cpu_read();
    test_simultaneous();
    test_dio_back_to_back();
    test_vid_run();
    test_dio_overrun();
    test_timeout();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
